// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and FSM encoding.
// Pure declarations: no latency, no flow control.
package fetch_stage_pkg;

  localparam int INST_WIDTH = 32;
  localparam int PC_INCR    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; head is visible combinationally while not empty.
// Latency: a push is visible at the head the cycle after. Push when full is ignored; pop when empty is ignored.
module fetch_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop,
  output logic [DW-1:0]            head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= push_dat;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited imem reads, response FIFO, output register. Optional FETCH_PERF_CNT_EN adds perf counters.
// Latency: response to inst one cycle (registered bypass when FIFO empty); stall holds inst and stops requests once credits run out.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  input  logic                  noop_next,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  output logic                  noop_curr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_dropped
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = INST_WIDTH + ADDR_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, inst_pc_q, inst_pc_d, target;
  logic [CW-1:0]         in_flight_q, in_flight_d, drop_q, drop_d, fifo_count;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d, noop_q, noop_d;
  logic                  credit_ok, accept, rsp_keep, rsp_drop, advance, bypass;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]         fifo_head;
  logic [1:0]            unused_redirect_bits;

  assign target               = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_bits = redirect_pc[1:0];

  // Credits cover both outstanding requests and buffered responses, so the FIFO can never overflow.
  assign credit_ok      = ({1'b0, in_flight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = (state_q == ST_RUN) && credit_ok;
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop  = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep  = imem_rsp_valid && (drop_q == '0);
  assign advance   = !inst_valid_q || !stall;
  assign bypass    = rsp_keep && fifo_empty && advance && !redirect;
  assign fifo_push = rsp_keep && !bypass && !redirect;
  assign fifo_pop  = advance && !fifo_empty && !redirect;

  assign in_flight_d = in_flight_q + CW'(accept) - CW'(imem_rsp_valid);

  fetch_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (redirect),
    .push     (fifo_push),
    .push_dat ({imem_rsp_data, rsp_pc_q}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (redirect) state_d = ST_FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    pc_d         = pc_q;
    rsp_pc_d     = rsp_pc_q;
    drop_d       = drop_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    noop_d       = noop_q;
    if (accept)   pc_d     = pc_q + ADDR_WIDTH'(PC_INCR);
    // Responses return in order, so the next kept response belongs to rsp_pc_q.
    if (rsp_keep) rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(PC_INCR);
    if (rsp_drop) drop_d   = drop_q - CW'(1);
    if (advance) begin
      if (inst_valid_q) noop_d = noop_next;
      if (!fifo_empty) begin
        inst_d       = fifo_head[EW-1 -: INST_WIDTH];
        inst_pc_d    = fifo_head[ADDR_WIDTH-1:0];
        inst_valid_d = 1'b1;
      end else if (rsp_keep) begin
        inst_d       = imem_rsp_data;
        inst_pc_d    = rsp_pc_q;
        inst_valid_d = 1'b1;
      end else begin
        inst_valid_d = 1'b0;
      end
    end
    if (redirect) begin
      pc_d         = target;
      rsp_pc_d     = target;
      drop_d       = in_flight_d;
      inst_valid_d = 1'b0;
      noop_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      in_flight_q  <= '0;
      drop_q       <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      noop_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      rsp_pc_q     <= rsp_pc_d;
      in_flight_q  <= in_flight_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      noop_q       <= noop_d;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign noop_curr  = noop_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_dropped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (rsp_keep && !redirect) perf_fetched_q <= perf_fetched_q + 32'd1;
      perf_dropped_q <= perf_dropped_q + 32'(rsp_drop)
                      + (redirect ? (32'(fifo_count) + 32'(rsp_keep)) : 32'd0);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with programmable latency, expected-instruction queue, directed scenarios.
module tb_fetch_stage;

  localparam int AW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data = '0;
  logic          redirect, stall, noop_next;
  logic [AW-1:0] redirect_pc;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid, noop_curr;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_WIDTH(AW), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .noop_next      (noop_next),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .noop_curr      (noop_curr)
  );

  typedef struct { logic [31:0] addr; logic [31:0] epc; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  mreq_t       mq[$];
  exp_t        eq[$];
  mreq_t       r_m;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] m_pc = '0;
  bit          noop_carry = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Memory + reference model: evaluated half a cycle before each rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete();
      eq.delete();
      imem_rsp_valid = 1'b0;
      m_pc           = 32'h0;
      noop_carry     = 1'b0;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_noop", 32'(noop_curr), 32'd0);
    end else begin
      if (imem_req_valid) chk("imem_addr", imem_addr, m_pc);
      chk("credit_bound", 32'(mq.size() <= DEPTH), 32'd1);
      if (inst_valid) begin
        chk("inst_expected", 32'(eq.size() > 0), 32'd1);
        if (eq.size() > 0) begin
          chk("inst_pc", inst_pc, eq[0].pc);
          chk("inst", inst, eq[0].data);
          chk("noop_curr", 32'(noop_curr), 32'(noop_carry));
        end
      end
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      if (inst_valid && !stall && !redirect && eq.size() > 0) begin
        void'(eq.pop_front());
        noop_carry = noop_next;
      end
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{addr: imem_addr, epc: m_pc, due: cyc + lat, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (imem_rsp_valid) begin
        r_m = mq.pop_front();
        if (!r_m.stale && !redirect) eq.push_back('{pc: r_m.epc, data: mem_word(r_m.epc)});
      end
      if (redirect) begin
        foreach (mq[i]) mq[i].stale = 1'b1;
        eq.delete();
        noop_carry = 1'b0;
        m_pc       = redirect_pc & ~32'd3;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    imem_req_ready = 1'b0;
    repeat (15) step();
    chk({nm, "_mem_empty"}, mq.size(), 32'd0);
    chk({nm, "_no_loss"}, eq.size(), 32'd0);
    chk({nm, "_idle"}, 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b1;
  endtask

  task automatic wait_pc(input string nm, input logic [31:0] pc);
    int n;
    for (n = 0; n < 60; n++) begin
      if (inst_valid && inst_pc == pc) break;
      step();
    end
    chk({nm, "_reached"}, 32'(n < 60), 32'd1);
  endtask

  initial begin
    logic [31:0] pcs [4];
    int          idx [4];
    int          got;
    int          n;
    logic [31:0] held_pc, held_inst;

    imem_req_ready = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    noop_next      = 1'b0;

    // 1: sequential stream, one instruction per cycle
    lat = 1;
    do_reset();
    got = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      step();
      if (inst_valid) begin
        pcs[got] = inst_pc;
        idx[got] = i;
        got++;
      end
    end
    chk("t1_count", got, 32'd4);
    for (int k = 0; k < 4; k++) chk("t1_pc", pcs[k], 32'(4 * k));
    chk("t1_back_to_back", idx[3] - idx[0], 32'd3);
    drain("t1");

    // 2: noop_next while pc 8 is presented squashes pc 12 only
    do_reset();
    wait_pc("t2", 32'h8);
    noop_next = 1'b1;
    step();
    noop_next = 1'b0;
    chk("t2_pc12", inst_pc, 32'hC);
    chk("t2_noop_set", 32'(noop_curr), 32'd1);
    step();
    chk("t2_pc16", inst_pc, 32'h10);
    chk("t2_noop_clr", 32'(noop_curr), 32'd0);

    // 3: redirect with two requests outstanding
    lat = 3;
    do_reset();
    for (n = 0; n < 40; n++) begin
      if (mq.size() == 2) break;
      step();
    end
    chk("t3_two_in_flight", 32'(n < 40), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("t3_flushed", 32'(inst_valid), 32'd0);
    for (n = 0; n < 40; n++) begin
      if (inst_valid) break;
      step();
    end
    chk("t3_first_pc", inst_pc, 32'h100);
    chk("t3_first_inst", inst, mem_word(32'h100));

    // 4: five-cycle stall with 3-cycle memory
    repeat (4) step();
    stall     = 1'b1;
    held_pc   = inst_pc;
    held_inst = inst;
    chk("t4_valid_at_stall", 32'(inst_valid), 32'd1);
    repeat (5) begin
      step();
      chk("t4_pc_held", inst_pc, held_pc);
      chk("t4_inst_held", inst, held_inst);
    end
    stall = 1'b0;
    drain("t4");

    // 5: redirect coincident with stall and an arriving response
    lat = 1;
    repeat (6) step();
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    step();
    stall    = 1'b0;
    redirect = 1'b0;
    chk("t5_flushed", 32'(inst_valid), 32'd0);
    for (n = 0; n < 40; n++) begin
      if (inst_valid) break;
      step();
    end
    chk("t5_first_pc", inst_pc, 32'h200);

    // 6: address wrap, then reset mid-stream
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (imem_req_valid && imem_addr == 32'hFFFF_FFFC) break;
      step();
    end
    chk("t6_top_req", 32'(n < 20), 32'd1);
    step();
    chk("t6_wrap_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_wrap_addr", imem_addr, 32'h0);
    wait_pc("t6_wrap_inst", 32'h0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_valid", 32'(inst_valid), 32'd0);
    chk("t6_rst_inst", inst, 32'd0);
    chk("t6_rst_pc", inst_pc, 32'd0);
    chk("t6_rst_noop", 32'(noop_curr), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    for (n = 0; n < 40; n++) begin
      if (inst_valid) break;
      step();
    end
    chk("t6_restart_pc", inst_pc, 32'h0);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
